// File: rtl/apb_fabric_n.sv
// ============================================================================
// Module   : apb_fabric_n
// Brief    : Registered APB interconnect, one initiator to NUM_TGT targets,
//            base/mask decode, decode-error response and timeout watchdog.
//            Optional error log enabled by APB_FABRIC_N_ERRLOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_fabric_n #(
    parameter int                      NUM_TGT  = 4,
    parameter logic [NUM_TGT*32-1:0]   TGT_BASE = {32'h0C00_0000, 32'h0200_0000,
                                                   32'h1000_0000, 32'h8000_0000},
    parameter logic [NUM_TGT*32-1:0]   TGT_MASK = {32'h03FF_FFFF, 32'h0000_FFFF,
                                                   32'h0000_0FFF, 32'h7FFF_FFFF},
    parameter int                      TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_psel,
    input  logic                    i_penable,
    input  logic                    i_pwrite,
    input  logic [31:0]             i_paddr,
    input  logic [31:0]             i_pwdata,
    input  logic [3:0]              i_pwstrb,
    output logic                    i_pready,
    output logic [31:0]             i_prdata,
    output logic                    i_pslverr,
    output logic [NUM_TGT-1:0]      t_psel,
    output logic                    t_penable,
    output logic                    t_pwrite,
    output logic [31:0]             t_paddr,
    output logic [31:0]             t_pwdata,
    output logic [3:0]              t_pwstrb,
    input  logic [NUM_TGT-1:0]      t_pready,
    input  logic [NUM_TGT*32-1:0]   t_prdata,
    input  logic [NUM_TGT-1:0]      t_pslverr
`ifdef APB_FABRIC_N_ERRLOG_EN
    ,
    output logic [15:0]             err_cnt,
    output logic [31:0]             err_addr
`endif
);

    localparam int              c_IW       = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    localparam int              c_CW       = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_SETUP  = 2'd1;
    localparam logic [1:0] c_S_ACCESS = 2'd2;
    localparam logic [1:0] c_S_RESP   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [c_IW-1:0]    r_idx;
    logic [c_CW-1:0]    r_cnt;

    logic               w_hit;
    logic [c_IW-1:0]    w_hit_idx;
    logic               w_tgt_ready;
    logic               w_tgt_err;
    logic [31:0]        w_tgt_rdata;
    logic               w_timeout;
    logic               w_capture;

    logic [c_IW-1:0]    w_idx_d;
    logic [NUM_TGT-1:0] w_psel_d;
    logic               w_penable_d;
    logic               w_pready_d;
    logic [31:0]        w_prdata_d;
    logic               w_pslverr_d;
    logic               w_log_err;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = NUM_TGT - 1; k >= 0; k--) begin
            if ((i_paddr & ~TGT_MASK[32*k +: 32]) == TGT_BASE[32*k +: 32]) begin
                w_hit     = 1'b1;
                w_hit_idx = c_IW'(k);
            end
        end
    end

    assign w_tgt_ready = t_pready[r_idx];
    assign w_tgt_err   = t_pslverr[r_idx];
    assign w_tgt_rdata = t_prdata[32*int'(r_idx) +: 32];
    assign w_timeout   = (r_cnt == c_CNT_LAST);
    assign w_capture   = (r_state == c_S_IDLE) && i_psel;

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE:   if (i_psel) w_next = w_hit ? c_S_SETUP : c_S_RESP;
            c_S_SETUP:  w_next = c_S_ACCESS;
            c_S_ACCESS: if (w_tgt_ready || w_timeout) w_next = c_S_RESP;
            default:    w_next = c_S_IDLE;
        endcase
    end

    // Next values for the registered outputs; response data is zero outside RESP.
    always_comb begin
        w_idx_d     = (r_state == c_S_IDLE) ? w_hit_idx : r_idx;
        w_psel_d    = '0;
        if (w_next == c_S_SETUP || w_next == c_S_ACCESS)
            w_psel_d = NUM_TGT'(1) << w_idx_d;
        w_penable_d = (w_next == c_S_ACCESS);
        w_pready_d  = (w_next == c_S_RESP);
        w_prdata_d  = 32'd0;
        w_pslverr_d = 1'b0;
        w_log_err   = 1'b0;
        if (w_capture && !w_hit) begin
            w_pslverr_d = 1'b1;
            w_log_err   = 1'b1;
        end else if (r_state == c_S_ACCESS) begin
            if (w_tgt_ready) begin
                w_prdata_d  = w_tgt_rdata;
                w_pslverr_d = w_tgt_err;
            end else if (w_timeout) begin
                w_pslverr_d = 1'b1;
                w_log_err   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            t_psel    <= '0;
            t_penable <= 1'b0;
            t_pwrite  <= 1'b0;
            t_paddr   <= 32'd0;
            t_pwdata  <= 32'd0;
            t_pwstrb  <= 4'd0;
            i_pready  <= 1'b0;
            i_prdata  <= 32'd0;
            i_pslverr <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_idx     <= w_idx_d;
            t_psel    <= w_psel_d;
            t_penable <= w_penable_d;
            i_pready  <= w_pready_d;
            i_prdata  <= w_prdata_d;
            i_pslverr <= w_pslverr_d;
            if (w_next == c_S_SETUP)
                r_cnt <= '0;
            else if (r_state == c_S_ACCESS)
                r_cnt <= r_cnt + 1'b1;
            if (w_capture && w_hit) begin
                t_pwrite <= i_pwrite;
                t_paddr  <= i_paddr & TGT_MASK[32*int'(w_hit_idx) +: 32];
                t_pwdata <= i_pwdata;
                t_pwstrb <= i_pwstrb;
            end
        end
    end

`ifdef APB_FABRIC_N_ERRLOG_EN
    logic [31:0] r_full_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full_addr <= 32'd0;
            err_cnt     <= 16'd0;
            err_addr    <= 32'd0;
        end else begin
            if (w_capture)
                r_full_addr <= i_paddr;
            if (w_log_err) begin
                if (err_cnt != 16'hFFFF)
                    err_cnt <= err_cnt + 16'd1;
                err_addr <= (r_state == c_S_IDLE) ? i_paddr : r_full_addr;
            end
        end
    end
`endif

    logic w_unused;
    assign w_unused = i_penable;

endmodule

`default_nettype wire

// File: tb/tb_apb_fabric_n.sv
// ============================================================================
// Module   : tb_apb_fabric_n
// Brief    : Directed self-checking bench for apb_fabric_n (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_fabric_n;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_psel, i_penable, i_pwrite;
    logic [31:0]  i_paddr, i_pwdata;
    logic [3:0]   i_pwstrb;
    logic         i_pready;
    logic [31:0]  i_prdata;
    logic         i_pslverr;
    logic [3:0]   t_psel;
    logic         t_penable, t_pwrite;
    logic [31:0]  t_paddr, t_pwdata;
    logic [3:0]   t_pwstrb;
    logic [3:0]   t_pready;
    logic [127:0] t_prdata;
    logic [3:0]   t_pslverr;
`ifdef APB_FABRIC_N_ERRLOG_EN
    logic [15:0]  err_cnt;
    logic [31:0]  err_addr;
`endif

    apb_fabric_n #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_psel(i_psel), .i_penable(i_penable), .i_pwrite(i_pwrite),
        .i_paddr(i_paddr), .i_pwdata(i_pwdata), .i_pwstrb(i_pwstrb),
        .i_pready(i_pready), .i_prdata(i_prdata), .i_pslverr(i_pslverr),
        .t_psel(t_psel), .t_penable(t_penable), .t_pwrite(t_pwrite),
        .t_paddr(t_paddr), .t_pwdata(t_pwdata), .t_pwstrb(t_pwstrb),
        .t_pready(t_pready), .t_prdata(t_prdata), .t_pslverr(t_pslverr)
`ifdef APB_FABRIC_N_ERRLOG_EN
        , .err_cnt(err_cnt), .err_addr(err_addr)
`endif
    );

    always #5 clk = ~clk;

    // Target models: fixed data/error, ready after tgt_wait ACCESS cycles.
    logic [31:0] tgt_data [4];
    logic        tgt_err  [4];
    logic [7:0]  tgt_wait [4];
    logic [7:0]  acc_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            acc_cnt <= 8'd0;
        else
            acc_cnt <= (t_penable && t_pready == 4'd0) ? acc_cnt + 8'd1 : 8'd0;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            t_pready[k]           = t_psel[k] && t_penable && (acc_cnt >= tgt_wait[k]);
            t_pslverr[k]          = tgt_err[k];
            t_prdata[32*k +: 32]  = tgt_data[k];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          lat, acc_cycles;
    logic [3:0]  psel_seen, strb_seen;
    logic [31:0] paddr_seen, wdata_seen, got_rdata;
    logic        pwrite_seen, got_err, zero_ok;

    task automatic do_xfer(input logic [31:0] addr, input logic wr,
                           input logic [31:0] wd, input logic [3:0] st);
        lat = 0; acc_cycles = 0; psel_seen = 0; strb_seen = 0; paddr_seen = 0;
        wdata_seen = 0; pwrite_seen = 0; got_rdata = 0; got_err = 0; zero_ok = 1;
        @(posedge clk); #1;
        i_psel = 1'b1; i_penable = 1'b0; i_pwrite = wr;
        i_paddr = addr; i_pwdata = wd; i_pwstrb = st;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            i_penable = 1'b1;
            psel_seen |= t_psel;
            if (t_psel != 4'd0) begin
                paddr_seen = t_paddr; strb_seen = t_pwstrb;
                wdata_seen = t_pwdata; pwrite_seen = t_pwrite;
            end
            if (t_penable) acc_cycles++;
            if (i_pready) begin
                lat = n; got_rdata = i_prdata; got_err = i_pslverr;
                break;
            end
            if (i_prdata != 32'd0 || i_pslverr) zero_ok = 1'b0;
        end
        if (lat == 0) check("xfer_budget", 32'd0, 32'd1);
        i_psel = 1'b0; i_penable = 1'b0;
        @(posedge clk); #1;
        check("pready_one_cycle", 32'(i_pready), 32'd0);
        check("resp_zero_idle", 32'(zero_ok && i_prdata == 32'd0 && !i_pslverr), 32'd1);
    endtask

    initial begin
        tgt_data[0] = 32'h5555_0000; tgt_err[0] = 0; tgt_wait[0] = 8'd2;
        tgt_data[1] = 32'h0000_00A5; tgt_err[1] = 0; tgt_wait[1] = 8'd0;
        tgt_data[2] = 32'hCAFE_0002; tgt_err[2] = 0; tgt_wait[2] = 8'd255;
        tgt_data[3] = 32'h0000_1234; tgt_err[3] = 1; tgt_wait[3] = 8'd0;
        rst = 1'b1; i_psel = 0; i_penable = 0; i_pwrite = 0;
        i_paddr = 0; i_pwdata = 0; i_pwstrb = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_t_psel", 32'(t_psel), 32'd0);
        check("rst_i_pready", 32'(i_pready), 32'd0);
        check("rst_t_paddr", t_paddr, 32'd0);
        check("rst_t_pwdata", t_pwdata, 32'd0);
`ifdef APB_FABRIC_N_ERRLOG_EN
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b0;

        // UART zero-wait read
        do_xfer(32'h1000_0004, 1'b0, 32'd0, 4'd0);
        check("uart_lat", 32'(lat), 32'd3);
        check("uart_psel", 32'(psel_seen), 32'h2);
        check("uart_paddr", paddr_seen, 32'h0000_0004);
        check("uart_rdata", got_rdata, 32'h0000_00A5);
        check("uart_err", 32'(got_err), 32'd0);

        // RAM write with two wait states
        do_xfer(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        check("ram_lat", 32'(lat), 32'd5);
        check("ram_psel", 32'(psel_seen), 32'h1);
        check("ram_paddr", paddr_seen, 32'h0000_1000);
        check("ram_strb", 32'(strb_seen), 32'h3);
        check("ram_wdata", wdata_seen, 32'hDEAD_BEEF);
        check("ram_pwrite", 32'(pwrite_seen), 32'd1);
        check("ram_err", 32'(got_err), 32'd0);
        check("ram_rdata_on_write", got_rdata, 32'h5555_0000);

        // Unmapped address
        do_xfer(32'h4000_0000, 1'b0, 32'd0, 4'd0);
        check("miss_lat", 32'(lat), 32'd1);
        check("miss_psel", 32'(psel_seen), 32'd0);
        check("miss_err", 32'(got_err), 32'd1);
        check("miss_rdata", got_rdata, 32'd0);
`ifdef APB_FABRIC_N_ERRLOG_EN
        check("miss_err_cnt", 32'(err_cnt), 32'd1);
        check("miss_err_addr", err_addr, 32'h4000_0000);
`endif

        // MTIMER never ready: abort after 8 ACCESS cycles
        do_xfer(32'h0200_0000, 1'b0, 32'd0, 4'd0);
        check("to_psel", 32'(psel_seen), 32'h4);
        check("to_access_cycles", 32'(acc_cycles), 32'd8);
        check("to_lat", 32'(lat), 32'd10);
        check("to_err", 32'(got_err), 32'd1);
        check("to_rdata", got_rdata, 32'd0);
`ifdef APB_FABRIC_N_ERRLOG_EN
        check("to_err_cnt", 32'(err_cnt), 32'd2);
        check("to_err_addr", err_addr, 32'h0200_0000);
`endif

        // PLIC reports slave error with data
        do_xfer(32'h0C00_0010, 1'b0, 32'd0, 4'd0);
        check("plic_psel", 32'(psel_seen), 32'h8);
        check("plic_paddr", paddr_seen, 32'h0000_0010);
        check("plic_err", 32'(got_err), 32'd1);
        check("plic_rdata", got_rdata, 32'h0000_1234);
`ifdef APB_FABRIC_N_ERRLOG_EN
        check("plic_err_cnt", 32'(err_cnt), 32'd2);
`endif

        // Reset in the middle of a RAM read
        tgt_wait[0] = 8'd20;
        @(posedge clk); #1;
        i_psel = 1'b1; i_pwrite = 1'b0; i_paddr = 32'h8000_0000;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_access", 32'({t_penable, t_psel}), 32'h11);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_t_psel", 32'(t_psel), 32'd0);
        check("mid_rst_penable", 32'(t_penable), 32'd0);
        check("mid_rst_i_pready", 32'(i_pready), 32'd0);
        check("mid_rst_t_paddr", t_paddr, 32'd0);
        rst = 1'b0; i_psel = 1'b0;

        do_xfer(32'h1000_0000, 1'b0, 32'd0, 4'd0);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_psel", 32'(psel_seen), 32'h2);
        check("post_rst_rdata", got_rdata, 32'h0000_00A5);
        check("post_rst_err", 32'(got_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
